dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus bundle: CPU port, DMA port and the single-port
// memory side, all grouped so the arbiter takes one interface port.
//   slave  : the arbiter's view (requests in, grants/data/memory drive out)
//   master : the environment's view (CPU, DMA engine and memory model)
interface dmem_arbiter_if;
  // CPU port
  logic        cpu_valid;
  logic [14:0] cpu_addr;
  logic        cpu_we;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_stall;
  // DMA port
  logic        dma_req;
  logic [14:0] dma_addr;
  logic        dma_we;
  logic [15:0] dma_din;
  logic        dma_lock;
  logic        dma_gnt;
  logic [15:0] dma_rdata;
  logic        dma_rvalid;
  logic        lock_abort;
  // single-port memory, asynchronous read
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_we, cpu_din,
    input  dma_req, dma_addr, dma_we, dma_din, dma_lock,
    input  mem_dout,
    output cpu_dout, cpu_stall,
    output dma_gnt, dma_rdata, dma_rvalid, lock_abort,
    output mem_addr, mem_we, mem_din
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_we, cpu_din,
    output dma_req, dma_addr, dma_we, dma_din, dma_lock,
    output mem_dout,
    input  cpu_dout, cpu_stall,
    input  dma_gnt, dma_rdata, dma_rvalid, lock_abort,
    input  mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// The CPU normally wins; a DMA port that has waited STARVE_LIMIT cycles is
// forced one slot. The DMA may lock the memory for multi-cycle ownership,
// bounded to LOCK_MAX cycles, after which the lock is force-released and
// lock_abort pulses.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_arbiter_if.slave (CPU port, DMA port, memory port)
// Upper half of the address space (addr[14]=1) is unmapped: writes there are
// granted but not performed, reads return zero.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 64
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_END = LW'(LOCK_MAX);

  typedef enum logic {ARB, LOCK} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] lock_cnt;
  logic          lock_block;   // set by a forced release until dma_lock drops
  logic          cpu_win, dma_win, stall;
  logic          starve, force_rel, lock_enter;
  logic [15:0]   rdata_q;
  logic          rvalid_q, abort_q;

  assign starve     = bus.dma_req && (wait_cnt == WAIT_SAT);
  // Budget exhausted while the DMA still holds the lock. A simultaneous
  // dma_lock drop is a normal release instead.
  assign force_rel  = (state == LOCK) && bus.dma_lock && (lock_cnt == LOCK_END);
  assign lock_enter = (state == ARB) && dma_win && bus.dma_lock && !lock_block;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (lock_enter) state_nxt = LOCK;
      LOCK:    if (!bus.dma_lock || (lock_cnt == LOCK_END)) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // grant decision
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    stall   = 1'b0;
    case (state)
      ARB: begin
        if (bus.cpu_valid && !starve) cpu_win = 1'b1;
        else if (bus.dma_req)         dma_win = 1'b1;
        stall = bus.cpu_valid && !cpu_win;
      end
      LOCK: begin
        if (!bus.dma_lock) begin
          // release cycle: only an uncontended DMA access goes through
          dma_win = bus.dma_req && !bus.cpu_valid;
          stall   = bus.cpu_valid;
        end else if (force_rel) begin
          // entry grant plus LOCK_MAX-1 locked cycles used the budget;
          // this cycle is handed back to the CPU
          cpu_win = bus.cpu_valid;
          dma_win = bus.dma_req && !bus.cpu_valid;
        end else begin
          dma_win = bus.dma_req;
          stall   = bus.cpu_valid;
        end
      end
      default: ;
    endcase
    if (reset) begin
      cpu_win = 1'b0;
      dma_win = 1'b0;
      stall   = 1'b0;
    end
  end

  // counters, lock bookkeeping and DMA read return
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      lock_cnt   <= '0;
      lock_block <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if (dma_win || force_rel)
        wait_cnt <= '0;
      else if (bus.dma_req && (wait_cnt != WAIT_SAT))
        wait_cnt <= wait_cnt + 1'b1;

      if (lock_enter)
        lock_cnt <= {{(LW-1){1'b0}}, 1'b1};
      else if (state == LOCK)
        lock_cnt <= (state_nxt == LOCK) ? lock_cnt + 1'b1 : '0;

      if (!bus.dma_lock) lock_block <= 1'b0;
      else if (force_rel) lock_block <= 1'b1;

      abort_q  <= force_rel;
      rvalid_q <= dma_win && !bus.dma_we;
      if (dma_win && !bus.dma_we)
        rdata_q <= bus.dma_addr[14] ? 16'h0000 : bus.mem_dout;
    end
  end

  assign bus.mem_addr   = dma_win ? bus.dma_addr : bus.cpu_addr;
  assign bus.mem_din    = dma_win ? bus.dma_din  : bus.cpu_din;
  assign bus.mem_we     = (cpu_win && bus.cpu_we && !bus.cpu_addr[14]) ||
                          (dma_win && bus.dma_we && !bus.dma_addr[14]);
  assign bus.cpu_dout   = bus.cpu_addr[14] ? 16'h0000 : bus.mem_dout;
  assign bus.cpu_stall  = stall;
  assign bus.dma_gnt    = dma_win;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;
  assign bus.lock_abort = abort_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int STARVE = 8;
  localparam int LMAX   = 64;

  logic clk = 1'b0;
  logic reset;
  dmem_arbiter_if dif();

  dmem_arbiter #(.STARVE_LIMIT(STARVE), .LOCK_MAX(LMAX)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  assign dif.mem_dout = mem[dif.mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reference model state: arbitration in terms of "who owns the memory"
  int          m_wait = 0;
  bit          m_locked = 1'b0;
  int          m_budget = 0;      // locked cycles still owed to the DMA
  bit          m_relock_ok = 1'b1;
  bit          m_rvalid = 1'b0;
  bit          m_abort = 1'b0;
  logic [15:0] m_rdata = 16'h0;

  // last observed values and model decisions
  logic        o_stall, o_gnt, o_mem_we, o_rvalid, o_abort;
  logic [15:0] o_dout, o_rdata;
  bit          e_cgo, e_dgo;

  task automatic step(input bit rst,
                      input bit cv, input logic [14:0] ca, input bit cw, input logic [15:0] cd,
                      input bit dr, input logic [14:0] da, input bit dw, input logic [15:0] dd,
                      input bit dl);
    bit cgo, dgo, stl, forced, wwe;
    logic [14:0] wa;
    logic [15:0] wd;
    @(negedge clk);
    o_rvalid = dif.dma_rvalid;
    o_rdata  = dif.dma_rdata;
    o_abort  = dif.lock_abort;
    chk("dma_rvalid", o_rvalid, m_rvalid);
    if (m_rvalid) chk("dma_rdata", o_rdata, m_rdata);
    chk("lock_abort", o_abort, m_abort);

    reset = rst;
    dif.cpu_valid = cv; dif.cpu_addr = ca; dif.cpu_we = cw; dif.cpu_din = cd;
    dif.dma_req = dr; dif.dma_addr = da; dif.dma_we = dw; dif.dma_din = dd;
    dif.dma_lock = dl;
    #1;

    cgo = 1'b0; dgo = 1'b0; stl = 1'b0; forced = 1'b0;
    if (!rst) begin
      if (!m_locked) begin
        cgo = cv && !(dr && m_wait >= STARVE);
        dgo = dr && !cgo;
        stl = cv && !cgo;
      end else if (!dl) begin
        dgo = dr && !cv;
        stl = cv;
      end else if (m_budget == 0) begin
        forced = 1'b1;
        cgo = cv;
        dgo = dr && !cv;
      end else begin
        dgo = dr;
        stl = cv;
      end
    end
    e_cgo = cgo;
    e_dgo = dgo;

    o_stall  = dif.cpu_stall;
    o_gnt    = dif.dma_gnt;
    o_mem_we = dif.mem_we;
    o_dout   = dif.cpu_dout;
    wwe = (cgo && cw && !ca[14]) || (dgo && dw && !da[14]);
    chk("cpu_stall", o_stall, stl);
    chk("dma_gnt", o_gnt, dgo);
    chk("mem_we", o_mem_we, wwe);
    if (cgo && !cw) chk("cpu_dout", o_dout, ca[14] ? 16'h0 : ref_mem[ca]);
    if (wwe) chk("mem_addr", dif.mem_addr, cgo ? ca : da);
    if (wwe) chk("mem_din", dif.mem_din, cgo ? cd : dd);
    wa = dif.mem_addr;
    wd = dif.mem_din;

    // advance the model to the state after this edge
    m_rvalid = dgo && !dw;
    if (dgo && !dw) m_rdata = da[14] ? 16'h0 : ref_mem[da];
    if (cgo && cw && !ca[14]) ref_mem[ca] = cd;
    if (dgo && dw && !da[14]) ref_mem[da] = dd;
    m_abort = forced;
    if (rst) begin
      m_wait = 0; m_locked = 1'b0; m_budget = 0; m_relock_ok = 1'b1;
      m_rvalid = 1'b0; m_abort = 1'b0;
    end else begin
      if (dgo || forced) m_wait = 0;
      else if (dr && m_wait < STARVE) m_wait++;
      if (m_locked && (!dl || forced)) m_locked = 1'b0;
      else if (!m_locked && dgo && dl && m_relock_ok) begin
        m_locked = 1'b1;
        m_budget = LMAX - 1;
      end else if (m_locked) m_budget--;
      if (!dl) m_relock_ok = 1'b1;
      else if (forced) m_relock_ok = 1'b0;
    end

    @(posedge clk);
    if (o_mem_we) mem[wa] = wd;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 15'h0, 1'b0, 16'h0, 1'b0, 15'h0, 1'b0, 16'h0, 1'b0);
  endtask

  function automatic logic [14:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 15'h4000 | 15'($urandom_range(0, 7));
    return 15'($urandom_range(0, 31));
  endfunction

  initial begin
    int nst, first, run, maxrun, nab, lock_left;
    bit cp, cw, dp, dw, dl, rst;
    logic [14:0] ca, da;
    logic [15:0] cd, dd;

    reset = 1'b1;
    dif.cpu_valid = 1'b0; dif.cpu_addr = '0; dif.cpu_we = 1'b0; dif.cpu_din = '0;
    dif.dma_req = 1'b0; dif.dma_addr = '0; dif.dma_we = 1'b0; dif.dma_din = '0;
    dif.dma_lock = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'(i * 7) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 7) ^ 16'h5A5A;
    end
    mem[5] = 16'h1234; ref_mem[5] = 16'h1234;

    // reset holds everything quiet even with both ports requesting
    repeat (3) step(1'b1, 1'b1, 15'h10, 1'b1, 16'h1, 1'b1, 15'h20, 1'b1, 16'h2, 1'b1);
    chk("rst_gnt", o_gnt, 0);
    chk("rst_mem_we", o_mem_we, 0);
    idle();

    // CPU write then read-back
    step(1'b0, 1'b1, 15'h0010, 1'b1, 16'hBEEF, 1'b0, 15'h0, 1'b0, 16'h0, 1'b0);
    chk("wr_mem_we", o_mem_we, 1);
    chk("wr_stall", o_stall, 0);
    step(1'b0, 1'b1, 15'h0010, 1'b0, 16'h0, 1'b0, 15'h0, 1'b0, 16'h0, 1'b0);
    chk("rd_beef", o_dout, 16'hBEEF);

    // idle DMA read
    step(1'b0, 1'b0, 15'h0, 1'b0, 16'h0, 1'b1, 15'h0005, 1'b0, 16'h0, 1'b0);
    chk("dma_gnt_idle", o_gnt, 1);
    idle();
    chk("dma_rv_idle", o_rvalid, 1);
    chk("dma_rd_idle", o_rdata, 16'h1234);

    // unmapped region
    step(1'b0, 1'b1, 15'h4000, 1'b1, 16'hCAFE, 1'b0, 15'h0, 1'b0, 16'h0, 1'b0);
    chk("hi_wr_we", o_mem_we, 0);
    chk("hi_wr_stall", o_stall, 0);
    step(1'b0, 1'b1, 15'h4000, 1'b0, 16'h0, 1'b0, 15'h0, 1'b0, 16'h0, 1'b0);
    chk("hi_rd_zero", o_dout, 16'h0000);

    // starvation: both held, 8 CPU slots then 1 DMA slot, repeating
    nst = 0; first = -1;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 15'h1, 1'b0, 16'h0, 1'b1, 15'h2, 1'b0, 16'h0, 1'b0);
      if (o_stall) begin
        nst++;
        if (first < 0) first = i;
      end
    end
    chk("starve_n", nst, 2);
    chk("starve_pos", first, 8);

    // long lock against a requesting CPU: bounded, aborted, CPU resumes
    run = 0; maxrun = 0; nab = 0;
    for (int i = 0; i < 76; i++) begin
      step(1'b0, 1'b1, 15'h4, 1'b0, 16'h0, i < 75, 15'h3, 1'b0, 16'h0, i < 75);
      if (o_stall) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (o_abort) nab++;
      if (i == 72 || i == 73) chk("cpu_after_abort", o_stall, 0);
    end
    chk("lock_stall_run", maxrun, LMAX);
    chk("abort_pulses", nab, 1);

    // reset in the third cycle of a lock
    step(1'b0, 1'b0, 15'h0, 1'b0, 16'h0, 1'b1, 15'h6, 1'b0, 16'h0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 15'h0, 1'b0, 16'h0, 1'b1, 15'h6, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 15'h0, 1'b0, 16'h0, 1'b1, 15'h6, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 15'h8, 1'b0, 16'h0, 1'b1, 15'h6, 1'b0, 16'h0, 1'b1);
    chk("post_rst_cpu", o_stall, 0);
    chk("post_rst_rv", o_rvalid, 0);
    idle();

    // randomized traffic with locks, unmapped accesses and stray resets
    cp = 1'b0; dp = 1'b0; lock_left = 0;
    ca = '0; da = '0; cw = 1'b0; dw = 1'b0; cd = '0; dd = '0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (lock_left == 0 && $urandom_range(0, 99) < 3) lock_left = $urandom_range(1, 90);
      dl = (lock_left > 0);
      if (lock_left > 0) lock_left--;
      if (!cp) begin
        cp = ($urandom_range(0, 99) < 60);
        ca = rand_addr(); cw = 1'($urandom_range(0, 1)); cd = 16'($urandom);
      end
      if (!dp) begin
        dp = ($urandom_range(0, 99) < (dl ? 90 : 40));
        da = rand_addr(); dw = 1'($urandom_range(0, 1)); dd = 16'($urandom);
      end
      step(rst, cp, ca, cw, cd, dp, da, dw, dd, dl);
      if (e_cgo) cp = 1'b0;
      if (e_dgo) dp = 1'b0;
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
